// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed N-digit seven-segment display driver. A display value
//   loaded at any time is held in a pending buffer and only becomes visible
//   at the next frame boundary, so a frame never mixes old and new digits.
//   One digit is lit per refresh period; each nibble is decoded to
//   active-low segments, with optional hex glyphs and leading-zero blanking.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous reset, active low
//   load        capture value/dp_in this cycle
//   value       nibble k = value[4k+3:4k] drives digit k (digit 0 = LSD)
//   dp_in       decimal point per digit, 1 = lit
//   blank_lz    1 = blank leading zero digits (live, not latched)
//   seg         {g,f,e,d,c,b,a}, active low
//   dp          decimal point, active low
//   an          digit enables, active low, one-hot-low
//   frame_done  one-cycle pulse when the scan wraps back to digit 0
module seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int HEX_MODE    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           prescaler;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] disp_val;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend;

  logic                    tick;
  logic                    wrap;
  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   zero_from;
  logic                    run;
  logic                    blank;
  logic [6:0]              seg_next;
  logic [NUM_DIGITS-1:0]   an_next;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      4'hF: g = 7'b0001110;
    endcase
    if (HEX_MODE == 0 && n > 4'd9) g = 7'b0111111;
    return g;
  endfunction

  assign tick = (prescaler == PRE_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  // zero_from[k] is set when nibbles k..NUM_DIGITS-1 are all zero; built
  // from the most significant digit down so each bit reuses the one above.
  always_comb begin
    run       = 1'b1;
    zero_from = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      nib[i] = disp_val[4*i +: 4];
    end
    for (int unsigned i = NUM_DIGITS; i > 0; i--) begin
      run            = run && (nib[i-1] == 4'd0);
      zero_from[i-1] = run;
    end
    blank    = blank_lz && (idx != '0) && zero_from[idx];
    seg_next = blank ? 7'h7F : glyph(nib[idx]);
    an_next      = '1;
    an_next[idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler  <= '0;
      idx        <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend       <= 1'b0;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end

      // A load landing on the wrap cycle bypasses the pending buffer so the
      // newest value is the one shown in the frame that starts now.
      if (load && !wrap) begin
        pend_val <= value;
        pend_dp  <= dp_in;
        pend     <= 1'b1;
      end else if (load && wrap) begin
        disp_val <= value;
        disp_dp  <= dp_in;
        pend     <= 1'b0;
      end else if (wrap && pend) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
        pend     <= 1'b0;
      end

      seg        <= seg_next;
      dp         <= ~disp_dp[idx];
      an         <= an_next;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int N     = 4;
  localparam int R     = 4;
  localparam int FRAME = N * R;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  seg_dec, seg_hex;
  logic        dp_dec, dp_hex;
  logic [3:0]  an_dec, an_hex;
  logic        fd_dec, fd_hex;

  seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .HEX_MODE(0)) u_dec (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg_dec), .dp(dp_dec), .an(an_dec),
    .frame_done(fd_dec)
  );

  seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .HEX_MODE(1)) u_hex (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg_hex), .dp(dp_hex), .an(an_hex),
    .frame_done(fd_hex)
  );

  always #5 clk = ~clk;

  int unsigned edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  typedef struct {
    int unsigned tag;
    logic [6:0]  seg_dec;
    logic [6:0]  seg_hex;
    logic        dp;
    logic [3:0]  an;
    logic        fd;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: cycles since reset, the value shown this frame, and
  // the newest load seen during this frame (shown from the next frame on).
  int unsigned t_cur = 0;
  logic [15:0] frame_val = '0;
  logic [3:0]  frame_dp = '0;
  logic [15:0] cand_val = '0;
  logic [3:0]  cand_dp = '0;
  bit          cand_valid = 0;

  function automatic logic [6:0] ref_glyph(input logic [3:0] n, input bit hex);
    logic [6:0] dec_tab [10];
    logic [6:0] hex_tab [6];
    dec_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    hex_tab = '{7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110,
                7'b0001110};
    if (n < 4'd10) return dec_tab[n];
    if (hex) return hex_tab[n - 4'd10];
    return 7'b0111111;
  endfunction

  task automatic chk(input string name, input int unsigned tag,
                     input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%h required=%h", name, tag, act, req);
    end
  endtask

  // Drives one clock's worth of inputs and queues what both DUTs must show
  // right after that clock edge.
  task automatic step(input bit r, input bit ld, input logic [15:0] v,
                      input logic [3:0] d, input bit blz);
    exp_t        e;
    int unsigned dig;
    bit          blank;
    logic [3:0]  n;
    rst_n    = r;
    load     = ld;
    value    = v;
    dp_in    = d;
    blank_lz = blz;
    e.tag    = edge_no + 1;
    if (!r) begin
      e.seg_dec  = 7'h7F;
      e.seg_hex  = 7'h7F;
      e.dp       = 1'b1;
      e.an       = 4'hF;
      e.fd       = 1'b0;
      t_cur      = 0;
      frame_val  = '0;
      frame_dp   = '0;
      cand_valid = 0;
    end else begin
      if (t_cur % FRAME == 0 && t_cur != 0 && cand_valid) begin
        frame_val  = cand_val;
        frame_dp   = cand_dp;
        cand_valid = 0;
      end
      dig       = (t_cur / R) % N;
      n         = frame_val[4*dig +: 4];
      blank     = blz && dig != 0 && ((frame_val >> (4*dig)) == 16'd0);
      e.seg_dec = blank ? 7'h7F : ref_glyph(n, 0);
      e.seg_hex = blank ? 7'h7F : ref_glyph(n, 1);
      e.dp      = ~frame_dp[dig];
      e.an      = ~(4'b0001 << dig);
      e.fd      = (t_cur % FRAME == FRAME - 1);
      if (ld) begin
        cand_val   = v;
        cand_dp    = d;
        cand_valid = 1;
      end
      t_cur++;
    end
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned cycles, input bit blz);
    for (int unsigned i = 0; i < cycles; i++) step(1, 0, 16'h0000, 4'h0, blz);
  endtask

  task automatic idle_to_wrap(input bit blz);
    while (t_cur % FRAME != FRAME - 1) step(1, 0, 16'h0000, 4'h0, blz);
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (expq.size() > 0 && expq[0].tag == edge_no) begin
      mon_e = expq.pop_front();
      chk("seg_dec", mon_e.tag, {1'b0, seg_dec}, {1'b0, mon_e.seg_dec});
      chk("seg_hex", mon_e.tag, {1'b0, seg_hex}, {1'b0, mon_e.seg_hex});
      chk("dp_dec",  mon_e.tag, {7'b0, dp_dec},  {7'b0, mon_e.dp});
      chk("dp_hex",  mon_e.tag, {7'b0, dp_hex},  {7'b0, mon_e.dp});
      chk("an_dec",  mon_e.tag, {4'b0, an_dec},  {4'b0, mon_e.an});
      chk("an_hex",  mon_e.tag, {4'b0, an_hex},  {4'b0, mon_e.an});
      chk("fd_dec",  mon_e.tag, {7'b0, fd_dec},  {7'b0, mon_e.fd});
      chk("fd_hex",  mon_e.tag, {7'b0, fd_hex},  {7'b0, mon_e.fd});
    end
  end

  initial begin
    bit          blz_state;
    bit          r;
    bit          ld;
    logic [15:0] v;

    repeat (3) step(0, 0, 16'h0000, 4'h0, 0);
    idle(22, 0);
    step(1, 1, 16'h1234, 4'h0, 0);
    idle(40, 0);

    step(1, 1, 16'h00A5, 4'h0, 1);
    idle(35, 1);
    idle(20, 0);

    step(1, 1, 16'hBEEF, 4'b0100, 0);
    idle(35, 0);

    step(1, 1, 16'h1111, 4'h0, 0);
    idle(3, 0);
    step(1, 1, 16'h2222, 4'h0, 0);
    idle(20, 0);
    idle_to_wrap(0);
    step(1, 1, 16'h3333, 4'h0, 0);
    idle(20, 0);

    step(1, 1, 16'h0000, 4'h0, 1);
    idle(30, 1);
    idle(5, 1);
    step(1, 1, 16'h5555, 4'hF, 1);
    idle(2, 1);
    repeat (2) step(0, 0, 16'h0000, 4'h0, 1);
    idle(40, 1);

    blz_state = 0;
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 299) != 0);
      ld = ($urandom_range(0, 7) == 0);
      v  = 16'($urandom);
      case ($urandom_range(0, 4))
        0: v = v & 16'h000F;
        1: v = v & 16'h00FF;
        2: v = v & 16'h0FFF;
        3: v = 16'h0000;
        default: ;
      endcase
      if ($urandom_range(0, 49) == 0) blz_state = ~blz_state;
      step(r, ld, v, 4'($urandom), blz_state);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 (unchecked expectations)", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
